// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch: tagged imem requests, in-order output FIFO, flush discard
// Optional feature macro IFETCH_BYPASS_EN: forward a response straight to decode when the FIFO is empty.
module ifetch_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter int FLUSH_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_in,
    output logic        pc_stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    input  logic        id_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(FLUSH_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [CW-1:0] occ_q, occ_d, out_q, out_d, disc_q, disc_d;
    logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d, t_wr_q, t_wr_d, t_rd_q, t_rd_d;
    logic [15:0]   f_instr_q [FIFO_DEPTH];
    logic [15:0]   f_pc_q    [FIFO_DEPTH];
    logic [15:0]   tag_q     [FIFO_DEPTH];

    logic credit, issue, rv_acc, rv_keep, push, pop, bypass;

    assign pop = (occ_q != '0) && id_ready;
    // An entry leaving this cycle frees its slot now, so latency-1 memory streams at full rate.
    assign credit = ({1'b0, occ_q} + {1'b0, out_q} - {{CW{1'b0}}, pop}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req  = !rst && (state_q == RUN) && credit && !flush;
    assign imem_addr = pc_in;
    assign issue     = imem_req && imem_gnt;
    assign pc_stall  = !issue;

    assign rv_acc  = imem_rvalid && (out_q != '0);
    assign rv_keep = rv_acc && (disc_q == '0) && !flush;

`ifdef IFETCH_BYPASS_EN
    assign bypass = (occ_q == '0) && rv_keep;
`else
    assign bypass = 1'b0;
`endif

    assign if_valid = (occ_q != '0) || bypass;
    assign if_instr = bypass ? imem_rdata : f_instr_q[f_rd_q];
    assign if_pc    = bypass ? tag_q[t_rd_q] : f_pc_q[f_rd_q];
    assign push     = rv_keep && !(bypass && id_ready) && ((occ_q != CW'(FIFO_DEPTH)) || pop);

    always_comb begin
        occ_d  = occ_q + CW'(push) - CW'(pop);
        f_wr_d = push ? f_wr_q + AW'(1) : f_wr_q;
        f_rd_d = pop ? f_rd_q + AW'(1) : f_rd_q;
        t_wr_d = issue ? t_wr_q + AW'(1) : t_wr_q;
        t_rd_d = rv_acc ? t_rd_q + AW'(1) : t_rd_q;
        out_d  = out_q + CW'(issue) - CW'(rv_acc);
        disc_d = disc_q;
        if (rv_acc && (disc_q != '0))
            disc_d = disc_q - CW'(1);
        // Tag queue survives a flush so the stale responses still retire in order.
        if (flush) begin
            occ_d  = '0;
            f_wr_d = '0;
            f_rd_d = '0;
            disc_d = out_q - CW'(rv_acc);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:  state_d = RUN;
            RUN:   state_d = RUN;
            DRAIN: begin
                wait_d = wait_q - WW'(1);
                if (wait_q == WW'(1))
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = DRAIN;
            wait_d  = WW'(FLUSH_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            occ_q   <= '0;
            out_q   <= '0;
            disc_q  <= '0;
            f_wr_q  <= '0;
            f_rd_q  <= '0;
            t_wr_q  <= '0;
            t_rd_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_instr_q[i] <= '0;
                f_pc_q[i]    <= '0;
                tag_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            occ_q   <= occ_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            f_wr_q  <= f_wr_d;
            f_rd_q  <= f_rd_d;
            t_wr_q  <= t_wr_d;
            t_rd_q  <= t_rd_d;
            if (push) begin
                f_instr_q[f_wr_q] <= imem_rdata;
                f_pc_q[f_wr_q]    <= tag_q[t_rd_q];
            end
            if (issue)
                tag_q[t_wr_q] <= pc_in;
        end
    end
endmodule
